// File: rtl/sfd_pkg.sv
// Shared types and constants for the serial frame decoder.
// FSM states, parity mode selectors and error codes.
package sfd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_FRAME   = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

endpackage

// File: rtl/sfd_shift_reg.sv
// MSB-first payload shifter with a running XOR of
// every bit shifted in since the last clear.
module sfd_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [W-1:0] o_data,
  output logic         o_xor
);

  logic [W-1:0] r_data;
  logic         r_xor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_xor  <= 1'b0;
    end else if (i_clr) begin
      r_data <= '0;
      r_xor  <= 1'b0;
    end else if (i_en) begin
      r_data <= {r_data[W-2:0], i_bit};
      r_xor  <= r_xor ^ i_bit;
    end
  end

  assign o_data = r_data;
  assign o_xor  = r_xor;

endmodule

// File: rtl/serial_frame_decoder.sv
// Serial frame decoder: start/sync/data/parity/stop framing,
// one-deep output holding register and saturating statistics.
module serial_frame_decoder
  import sfd_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] LAST = BCW'(DATA_W - 1);

  state_t            r_state;
  logic [BCW-1:0]    r_bcnt;
  logic              r_par_err;
  logic              r_frm_err;
  logic              r_done;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_err_valid;
  logic [1:0]        r_err_code;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [CNT_W-1:0]  r_err_cnt;

  logic [DATA_W-1:0] w_data;
  logic              w_xor;
  logic              w_clr;
  logic              w_shift;
  logic              w_ones;
  logic              w_par_bad;
  logic              w_good;
  logic              w_overrun;
  logic              w_load;
  logic              w_err;
  logic [1:0]        w_code;

  assign w_clr   = (r_state == S_SYNC) && serial_in;
  assign w_shift = (r_state == S_DATA);

  sfd_shift_reg #(
    .W (DATA_W)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (w_shift),
    .i_bit  (serial_in),
    .o_data (w_data),
    .o_xor  (w_xor)
  );

  assign w_ones    = w_xor ^ serial_in;
  assign w_par_bad = (PARITY_MODE == PAR_ODD) ? ~w_ones : w_ones;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bcnt    <= '0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!serial_in) r_state <= S_SYNC;
        end
        S_SYNC: begin
          if (serial_in) begin
            r_state   <= S_DATA;
            r_bcnt    <= '0;
            r_par_err <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (r_bcnt == LAST) begin
            r_state <= (PARITY_MODE == PAR_NONE) ? S_STOP : S_PARITY;
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        S_PARITY: begin
          r_par_err <= w_par_bad;
          r_state   <= S_STOP;
        end
        S_STOP: begin
          r_done    <= 1'b1;
          r_frm_err <= ~serial_in;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Frame outcome is committed one edge after the stop-bit sample.
  assign w_good    = r_done && !r_frm_err && !r_par_err;
  assign w_overrun = w_good && r_out_valid && !out_ready;
  assign w_load    = w_good && !w_overrun;
  assign w_err     = r_done && !w_load;
  assign w_code    = r_frm_err ? ERR_FRAME :
                     r_par_err ? ERR_PARITY : ERR_OVERRUN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_err_valid <= w_err;
      r_err_code  <= w_err ? w_code : ERR_NONE;
      if (w_load) r_out_data <= w_data;
      r_out_valid <= w_load | (r_out_valid & ~out_ready);
      if (w_load && r_frame_cnt != '1)
        r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_err && r_err_cnt != '1)
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign err_valid = r_err_valid;
  assign err_code  = r_err_code;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_serial_frame_decoder.sv
// Directed bench for serial_frame_decoder: an 8-bit even-parity
// instance and a 12-bit odd-parity instance with 2-bit counters.
module tb_serial_frame_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sa = 1'b1;
  logic        sb = 1'b1;
  logic        ra = 1'b1;
  logic        rb = 1'b1;

  logic [7:0]  da;
  logic        va;
  logic        eva;
  logic [1:0]  eca;
  logic [15:0] fca;
  logic [15:0] eca_cnt;

  logic [11:0] db;
  logic        vb;
  logic        evb;
  logic [1:0]  ecb;
  logic [1:0]  fcb;
  logic [1:0]  ecb_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_frame_decoder #(
    .DATA_W (8), .PARITY_MODE (1), .CNT_W (16)
  ) dut_a (
    .clk (clk), .rst (rst), .serial_in (sa),
    .out_data (da), .out_valid (va), .out_ready (ra),
    .err_valid (eva), .err_code (eca),
    .frame_cnt (fca), .err_cnt (eca_cnt)
  );

  serial_frame_decoder #(
    .DATA_W (12), .PARITY_MODE (2), .CNT_W (2)
  ) dut_b (
    .clk (clk), .rst (rst), .serial_in (sb),
    .out_data (db), .out_valid (vb), .out_ready (rb),
    .err_valid (evb), .err_code (ecb),
    .frame_cnt (fcb), .err_cnt (ecb_cnt)
  );

  task automatic send_bit(input logic b, input bit sel);
    if (sel) sb = b; else sa = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_body(input logic [31:0] d, input int w,
                           input logic p, input logic s, input bit sel);
    send_bit(1'b1, sel);
    for (int i = w - 1; i >= 0; i--) send_bit(d[i], sel);
    send_bit(p, sel);
    send_bit(s, sel);
  endtask

  task automatic send_frame(input logic [31:0] d, input int w,
                            input logic p, input logic s, input bit sel);
    send_bit(1'b0, sel);
    send_body(d, w, p, s, sel);
  endtask

  task automatic idle(input int n);
    sa = 1'b1;
    sb = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    sa = 1'b1;
    sb = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (da !== 8'h00 || va !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_a: data=%h valid=%b want 00/0", da, va);
    end
    total++;
    if (eva !== 1'b0 || eca !== 2'b00) begin
      bad++;
      $display("FAIL reset_err_a: ev=%b code=%b want 0/00", eva, eca);
    end
    total++;
    if (fca !== 16'd0 || eca_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_cnt_a: fc=%0d ec=%0d want 0/0", fca, eca_cnt);
    end
    total++;
    if (db !== 12'h000 || vb !== 1'b0 || fcb !== 2'd0 || ecb_cnt !== 2'd0) begin
      bad++;
      $display("FAIL reset_b: data=%h v=%b fc=%0d ec=%0d want 0", db, vb, fcb, ecb_cnt);
    end
  endtask

  task automatic test_good();
    do_reset();
    ra = 1'b1;
    send_frame(32'hA5, 8, 1'b0, 1'b1, 1'b0);
    idle(1);
    total++;
    if (va !== 1'b1 || da !== 8'hA5) begin
      bad++;
      $display("FAIL good_load: v=%b data=%h want 1/a5", va, da);
    end
    total++;
    if (fca !== 16'd1 || eva !== 1'b0) begin
      bad++;
      $display("FAIL good_cnt: fc=%0d ev=%b want 1/0", fca, eva);
    end
    idle(1);
    total++;
    if (va !== 1'b0 || da !== 8'hA5) begin
      bad++;
      $display("FAIL good_pulse: v=%b data=%h want 0/a5", va, da);
    end
  endtask

  task automatic test_parity_err();
    do_reset();
    ra = 1'b1;
    send_frame(32'hA5, 8, 1'b1, 1'b1, 1'b0);
    idle(1);
    total++;
    if (eva !== 1'b1 || eca !== 2'b01 || va !== 1'b0) begin
      bad++;
      $display("FAIL parity_err: ev=%b code=%b v=%b want 1/01/0", eva, eca, va);
    end
    total++;
    if (eca_cnt !== 16'd1 || fca !== 16'd0) begin
      bad++;
      $display("FAIL parity_cnt: ec=%0d fc=%0d want 1/0", eca_cnt, fca);
    end
    idle(1);
    total++;
    if (eva !== 1'b0) begin
      bad++;
      $display("FAIL parity_pulse: ev=%b want 0", eva);
    end
  endtask

  task automatic test_framing();
    do_reset();
    ra = 1'b1;
    send_frame(32'h3C, 8, 1'b0, 1'b0, 1'b0);
    idle(1);
    total++;
    if (eva !== 1'b1 || eca !== 2'b10 || va !== 1'b0) begin
      bad++;
      $display("FAIL framing: ev=%b code=%b v=%b want 1/10/0", eva, eca, va);
    end
    total++;
    if (eca_cnt !== 16'd1 || fca !== 16'd0) begin
      bad++;
      $display("FAIL framing_cnt: ec=%0d fc=%0d want 1/0", eca_cnt, fca);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    ra = 1'b0;
    send_frame(32'h11, 8, 1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    total++;
    if (va !== 1'b1 || da !== 8'h11 || fca !== 16'd1) begin
      bad++;
      $display("FAIL ovr_first: v=%b data=%h fc=%0d want 1/11/1", va, da, fca);
    end
    send_body(32'h22, 8, 1'b0, 1'b1, 1'b0);
    idle(1);
    total++;
    if (eva !== 1'b1 || eca !== 2'b11) begin
      bad++;
      $display("FAIL ovr_err: ev=%b code=%b want 1/11", eva, eca);
    end
    total++;
    if (va !== 1'b1 || da !== 8'h11 || fca !== 16'd1 || eca_cnt !== 16'd1) begin
      bad++;
      $display("FAIL ovr_hold: v=%b data=%h fc=%0d ec=%0d want 1/11/1/1",
               va, da, fca, eca_cnt);
    end
    ra = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ra = 1'b0;
    send_frame(32'h11, 8, 1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_body(32'h22, 8, 1'b0, 1'b1, 1'b0);
    ra = 1'b1;
    idle(1);
    total++;
    if (eva !== 1'b0 || va !== 1'b1 || da !== 8'h22) begin
      bad++;
      $display("FAIL b2b_accept: ev=%b v=%b data=%h want 0/1/22", eva, va, da);
    end
    total++;
    if (fca !== 16'd2 || eca_cnt !== 16'd0) begin
      bad++;
      $display("FAIL b2b_cnt: fc=%0d ec=%0d want 2/0", fca, eca_cnt);
    end
    idle(1);
    total++;
    if (va !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: v=%b want 0", va);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    ra = 1'b1;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    sa = 1'b1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    send_frame(32'h0F, 8, 1'b0, 1'b1, 1'b0);
    idle(1);
    total++;
    if (va !== 1'b1 || da !== 8'h0F) begin
      bad++;
      $display("FAIL midrst_data: v=%b data=%h want 1/0f", va, da);
    end
    total++;
    if (fca !== 16'd1 || eca_cnt !== 16'd0) begin
      bad++;
      $display("FAIL midrst_cnt: fc=%0d ec=%0d want 1/0", fca, eca_cnt);
    end
  endtask

  task automatic test_sync_abort();
    int pulses;
    do_reset();
    ra = 1'b1;
    pulses = 0;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (eva === 1'b1 || va === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0 || eca_cnt !== 16'd0) begin
      bad++;
      $display("FAIL sync_abort: events=%0d ec=%0d want 0/0", pulses, eca_cnt);
    end
    send_frame(32'h5A, 8, 1'b0, 1'b1, 1'b0);
    idle(1);
    total++;
    if (va !== 1'b1 || da !== 8'h5A || fca !== 16'd1) begin
      bad++;
      $display("FAIL sync_rearm: v=%b data=%h fc=%0d want 1/5a/1", va, da, fca);
    end
  endtask

  task automatic test_odd12();
    do_reset();
    rb = 1'b1;
    send_frame(32'hABC, 12, 1'b0, 1'b1, 1'b1);
    idle(1);
    total++;
    if (vb !== 1'b1 || db !== 12'hABC || evb !== 1'b0) begin
      bad++;
      $display("FAIL odd12_good: v=%b data=%h ev=%b want 1/abc/0", vb, db, evb);
    end
    send_frame(32'hABC, 12, 1'b1, 1'b1, 1'b1);
    idle(1);
    total++;
    if (evb !== 1'b1 || ecb !== 2'b01 || ecb_cnt !== 2'd1) begin
      bad++;
      $display("FAIL odd12_bad: ev=%b code=%b ec=%0d want 1/01/1", evb, ecb, ecb_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    rb = 1'b1;
    send_frame(32'h123, 12, 1'b1, 1'b1, 1'b1);
    idle(1);
    send_frame(32'h456, 12, 1'b0, 1'b1, 1'b1);
    idle(1);
    total++;
    if (fcb !== 2'd2) begin
      bad++;
      $display("FAIL sat_mid: fc=%0d want 2", fcb);
    end
    send_frame(32'hFFF, 12, 1'b1, 1'b1, 1'b1);
    idle(1);
    send_frame(32'h001, 12, 1'b0, 1'b1, 1'b1);
    idle(1);
    send_frame(32'h800, 12, 1'b0, 1'b1, 1'b1);
    idle(1);
    total++;
    if (fcb !== 2'd3 || db !== 12'h800 || ecb_cnt !== 2'd0) begin
      bad++;
      $display("FAIL sat_end: fc=%0d data=%h ec=%0d want 3/800/0", fcb, db, ecb_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_parity_err();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_sync_abort();
    test_odd12();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
